// File: rtl/memrsp_pkg.sv
// Shared types and constants for the bridge memory responder.
package memrsp_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_BEAT = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } wr_state_e;

  // Stall LFSR: x^8 + x^6 + x^5 + x^4, shifting towards the MSB
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Overlay the strobed bytes of new_word onto old_word
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/memrsp_rd_ch.sv
// Read channel: accepts a request, holds a 4-word snapshot, waits the
// configured latency, then streams 1 or 4 beats without backpressure.
//
// state  | meaning
// R_IDLE | ready to accept a read
// R_WAIT | latency down-counter running (absent when RD_LAT=1)
// R_BEAT | driving one return beat per cycle
module memrsp_rd_ch
  import memrsp_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         req,
  input  logic         line,
  input  logic         stall,
  input  logic [127:0] snap_in,
  output logic         rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data
);

  rd_state_e    state, state_d;
  logic [15:0]  lat_cnt, lat_cnt_d;
  logic [1:0]   beat, beat_d;
  logic         line_q, line_d;
  logic [127:0] snap_q, snap_d;
  logic [31:0]  data_q, data_d;
  logic         last_beat;

  assign last_beat = (beat == (line_q ? 2'd3 : 2'd0));
  assign rdy       = (state == R_IDLE) && !stall;
  assign ret_valid = (state == R_BEAT);
  assign ret_last  = ret_valid && last_beat;
  assign ret_data  = data_q;

  // Next-state, latency count, beat index and return data selection
  always_comb begin
    state_d   = state;
    lat_cnt_d = lat_cnt;
    beat_d    = beat;
    line_d    = line_q;
    snap_d    = snap_q;
    data_d    = data_q;
    case (state)
      R_IDLE: begin
        if (req && rdy) begin
          snap_d = snap_in;
          line_d = line;
          beat_d = 2'd0;
          if (RD_LAT == 1) begin
            state_d = R_BEAT;
            data_d  = snap_in[31:0];
          end else begin
            state_d   = R_WAIT;
            lat_cnt_d = 16'(RD_LAT - 2);
          end
        end
      end
      R_WAIT: begin
        if (lat_cnt == 16'd0) begin
          state_d = R_BEAT;
          data_d  = snap_q[31:0];
        end else begin
          lat_cnt_d = lat_cnt - 16'd1;
        end
      end
      R_BEAT: begin
        if (last_beat) begin
          state_d = R_IDLE;
        end else begin
          beat_d = beat + 2'd1;
          data_d = snap_q[{beat + 2'd1, 5'd0} +: 32];
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Read channel registers; reset aborts any burst in flight
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= R_IDLE;
      lat_cnt <= '0;
      beat    <= '0;
      line_q  <= 1'b0;
      snap_q  <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_d;
      lat_cnt <= lat_cnt_d;
      beat    <= beat_d;
      line_q  <= line_d;
      snap_q  <= snap_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/bridge_mem_responder.sv
// Behavioural memory slave for the cache-side bridge interface.
// Holds the word array and the write channel; the read channel lives in
// memrsp_rd_ch. Optional macro MEMRSP_RAND_STALL_EN adds LFSR-driven
// pseudo-random deassertion of rd_rdy/wr_rdy.
//
// state  | meaning
// W_IDLE | ready to accept a write
// W_BUSY | post-write hold-off, down-counter running
module bridge_mem_responder
  import memrsp_pkg::*;
#(
  parameter int MEM_WORDS = 16384,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] rd_idx, wr_idx;
  logic [AW-1:0] snap_idx [4];
  logic [127:0]  snap;
  logic          rd_line, wr_line, wr_acc;
  logic          rd_stall, wr_stall;
  wr_state_e     w_state, w_state_d;
  logic [15:0]   w_cnt, w_cnt_d;
  logic          unused_addr_bits;

  assign rd_idx  = rd_addr[2 +: AW];
  assign wr_idx  = wr_addr[2 +: AW];
  assign rd_line = (rd_type == TYPE_LINE);
  assign wr_line = (wr_type == TYPE_LINE);
  assign wr_rdy  = (w_state == W_IDLE) && !wr_stall;
  assign wr_acc  = wr_req && wr_rdy;
  assign unused_addr_bits = ^{rd_addr[1:0], wr_addr[1:0]};

`ifdef MEMRSP_RAND_STALL_EN
  logic [7:0] lfsr;

  // Free-running stall generator
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr <= LFSR_SEED;
    else          lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  assign rd_stall = lfsr[0];
  assign wr_stall = lfsr[1];
`else
  assign rd_stall = 1'b0;
  assign wr_stall = 1'b0;
`endif

  // Snapshot for the read channel, with a same-edge write merged in
  always_comb begin
    snap = '0;
    for (int i = 0; i < 4; i++) begin
      snap_idx[i] = rd_line ? {rd_idx[AW-1:2], 2'(i)} : rd_idx;
      snap[32*i +: 32] = mem[snap_idx[i]];
      if (wr_acc) begin
        if (wr_line && (snap_idx[i][AW-1:2] == wr_idx[AW-1:2]))
          snap[32*i +: 32] = wr_data[{snap_idx[i][1:0], 5'd0} +: 32];
        else if (!wr_line && (snap_idx[i] == wr_idx))
          snap[32*i +: 32] = merge_bytes(mem[wr_idx], wr_data[31:0], wr_wstrb);
      end
    end
  end

  // Array commit on write accept; contents survive reset
  always_ff @(posedge aclk) begin
    if (wr_acc) begin
      if (wr_line) begin
        for (int i = 0; i < 4; i++)
          mem[{wr_idx[AW-1:2], 2'(i)}] <= wr_data[32*i +: 32];
      end else begin
        mem[wr_idx] <= merge_bytes(mem[wr_idx], wr_data[31:0], wr_wstrb);
      end
    end
  end

  // Write channel next-state and busy down-counter
  always_comb begin
    w_state_d = w_state;
    w_cnt_d   = w_cnt;
    case (w_state)
      W_IDLE: begin
        if (wr_acc && (WR_LAT > 0)) begin
          w_state_d = W_BUSY;
          w_cnt_d   = 16'(WR_LAT - 1);
        end
      end
      W_BUSY: begin
        if (w_cnt == 16'd0) w_state_d = W_IDLE;
        else                w_cnt_d   = w_cnt - 16'd1;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
    end else begin
      w_state <= w_state_d;
      w_cnt   <= w_cnt_d;
    end
  end

  memrsp_rd_ch #(.RD_LAT(RD_LAT)) u_rd_ch (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req       (rd_req),
    .line      (rd_line),
    .stall     (rd_stall),
    .snap_in   (snap),
    .rdy       (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data)
  );

endmodule

// File: tb/tb_bridge_mem_responder.sv
// Directed bench for bridge_mem_responder with a transaction-level
// memory/timing model checked every cycle plus literal spot checks.
module tb_bridge_mem_responder;

  localparam int MEM_WORDS = 16384;
  localparam int RD_LAT    = 2;
  localparam int WR_LAT    = 2;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_type = 3'b010;
  logic [31:0]  rd_addr = '0;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = 3'b010;
  logic [31:0]  wr_addr = '0;
  logic [3:0]   wr_wstrb = '0;
  logic [127:0] wr_data = '0;
  logic         wr_rdy;

  bridge_mem_responder #(.MEM_WORDS(MEM_WORDS), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int          c;
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic [31:0] mdl [int];
  beat_t       exp_q [$];
  int          rd_free = 0;
  int          wr_free = 0;
  logic [31:0] exp_data = '0;

  logic [31:0] seen_data [$];
  logic        seen_last [$];
  int          seen_cyc  [$];
  int          acc_edges [$];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'(MEM_WORDS - 1));
  endfunction

  function automatic logic [31:0] rd_mdl(input int i);
    return mdl.exists(i) ? mdl[i] : 32'h0;
  endfunction

  // Compare DUT against the model, then apply any accepts happening at the next edge
  always @(negedge aclk) begin
    beat_t       b;
    int          nb, base, w;
    logic [31:0] nw;
    if (!aresetn) begin
      exp_q.delete();
      rd_free  = 0;
      wr_free  = 0;
      exp_data = '0;
    end else begin
      chk("rd_rdy", rd_rdy, cyc >= rd_free);
      chk("wr_rdy", wr_rdy, cyc >= wr_free);
      while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        b = exp_q.pop_front();
        chk("missed_beat", 1'b0, 1'b1);
      end
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        b = exp_q.pop_front();
        chk("ret_valid", ret_valid, 1'b1);
        chk("ret_last", ret_last, b.l);
        chk("ret_data", ret_data, b.d);
        exp_data = b.d;
      end else begin
        chk("ret_valid_idle", ret_valid, 1'b0);
        chk("ret_last_idle", ret_last, 1'b0);
        chk("ret_data_hold", ret_data, exp_data);
      end
      if (ret_valid) begin
        seen_data.push_back(ret_data);
        seen_last.push_back(ret_last);
        seen_cyc.push_back(cyc);
      end
      if (wr_req && cyc >= wr_free) begin
        if (wr_type == 3'b100) begin
          for (int k = 0; k < 4; k++) mdl[(widx(wr_addr) & ~3) + k] = wr_data[32*k +: 32];
        end else begin
          w  = widx(wr_addr);
          nw = rd_mdl(w);
          for (int k = 0; k < 4; k++) if (wr_wstrb[k]) nw[8*k +: 8] = wr_data[8*k +: 8];
          mdl[w] = nw;
        end
        wr_free = cyc + 1 + WR_LAT;
      end
      if (rd_req && cyc >= rd_free) begin
        nb   = (rd_type == 3'b100) ? 4 : 1;
        base = (nb == 4) ? (widx(rd_addr) & ~3) : widx(rd_addr);
        for (int k = 0; k < nb; k++)
          exp_q.push_back('{c: cyc + RD_LAT + k, d: rd_mdl(base + k), l: (k == nb - 1)});
        rd_free = cyc + RD_LAT + nb;
        acc_edges.push_back(cyc + 1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic wait_wr_accept();
    int n = 0;
    @(negedge aclk);
    while (!wr_rdy && n < 50) begin n++; @(negedge aclk); end
    chk("wr_accept", wr_rdy, 1'b1);
    @(posedge aclk); #2;
  endtask

  task automatic wait_rd_accept();
    int n = 0;
    @(negedge aclk);
    while (!rd_rdy && n < 50) begin n++; @(negedge aclk); end
    chk("rd_accept", rd_rdy, 1'b1);
    @(posedge aclk); #2;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] t,
                          input logic [3:0] s, input logic [127:0] d);
    wr_req = 1'b1; wr_addr = a; wr_type = t; wr_wstrb = s; wr_data = d;
    wait_wr_accept();
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] t);
    rd_req = 1'b1; rd_addr = a; rd_type = t;
    wait_rd_accept();
    rd_req = 1'b0;
  endtask

  task automatic clear_seen();
    seen_data.delete(); seen_last.delete(); seen_cyc.delete(); acc_edges.delete();
  endtask

  logic [31:0] line_vals [4];

  // ---------------- directed sequence ----------------
  initial begin
    line_vals[0] = 32'h00000000; line_vals[1] = 32'h11111111;
    line_vals[2] = 32'h22222222; line_vals[3] = 32'h33333333;

    // reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_rd_rdy", rd_rdy, 1'b1);
    chk("rst_wr_rdy", wr_rdy, 1'b1);
    chk("rst_ret_valid", ret_valid, 1'b0);
    chk("rst_ret_last", ret_last, 1'b0);
    chk("rst_ret_data", ret_data, 32'h0);
    @(posedge aclk); #2;
    aresetn = 1'b1;
    idle(1);

    // line write then line read from mid-line address
    do_write(32'h1000, 3'b100, 4'h0, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000});
    idle(3);
    clear_seen();
    do_read(32'h1008, 3'b100);
    idle(8);
    chk("line_beats", seen_data.size(), 4);
    for (int k = 0; k < 4 && k < seen_data.size(); k++) begin
      chk("line_data", seen_data[k], line_vals[k]);
      chk("line_last", seen_last[k], (k == 3));
    end
    if (seen_cyc.size() > 0 && acc_edges.size() > 0)
      chk("line_latency", seen_cyc[0] + 1 - acc_edges[0], 2);

    // strobed write
    do_write(32'h2000, 3'b010, 4'hF, {96'h0, 32'hAABBCCDD});
    do_write(32'h2000, 3'b010, 4'b0101, {96'h0, 32'h11223344});
    idle(3);
    clear_seen();
    do_read(32'h2000, 3'b010);
    idle(5);
    chk("strb_beats", seen_data.size(), 1);
    if (seen_data.size() > 0) begin
      chk("strb_data", seen_data[0], 32'hAA22CC44);
      chk("strb_last", seen_last[0], 1'b1);
    end

    // same-edge write forwarding into the read snapshot
    do_write(32'h3000, 3'b010, 4'hF, {96'h0, 32'h0});
    idle(3);
    clear_seen();
    wr_req = 1'b1; wr_addr = 32'h3000; wr_type = 3'b010; wr_wstrb = 4'hF; wr_data = {96'h0, 32'hDEADBEEF};
    rd_req = 1'b1; rd_addr = 32'h3000; rd_type = 3'b010;
    @(negedge aclk);
    chk("fwd_both_rdy", {rd_rdy, wr_rdy}, 2'b11);
    @(posedge aclk); #2;
    wr_req = 1'b0; rd_req = 1'b0;
    idle(5);
    chk("fwd_beats", seen_data.size(), 1);
    if (seen_data.size() > 0) chk("fwd_data", seen_data[0], 32'hDEADBEEF);

    // address aliasing above the array size
    do_write(32'h0001_0004, 3'b010, 4'hF, {96'h0, 32'h12345678});
    idle(3);
    clear_seen();
    do_read(32'h0000_0004, 3'b010);
    idle(5);
    chk("alias_beats", seen_data.size(), 1);
    if (seen_data.size() > 0) chk("alias_data", seen_data[0], 32'h12345678);

    // back-to-back line reads with rd_req held high
    clear_seen();
    rd_req = 1'b1; rd_addr = 32'h1000; rd_type = 3'b100;
    wait_rd_accept();
    rd_addr = 32'h1004;
    wait_rd_accept();
    rd_req = 1'b0;
    idle(8);
    chk("b2b_accepts", acc_edges.size(), 2);
    if (acc_edges.size() == 2) chk("b2b_accept_gap", acc_edges[1] - acc_edges[0], 6);
    chk("b2b_beats", seen_data.size(), 8);
    if (seen_data.size() == 8) begin
      chk("b2b_beat_gap", seen_cyc[4] - seen_cyc[3], 3);
      for (int k = 0; k < 4; k++) chk("b2b_data2", seen_data[4 + k], line_vals[k]);
    end

    // write busy window
    do_write(32'h5000, 3'b010, 4'hF, {96'h0, 32'h55AA55AA});
    @(negedge aclk); chk("wbusy_c0", wr_rdy, 1'b0);
    @(negedge aclk); chk("wbusy_c1", wr_rdy, 1'b0);
    @(negedge aclk); chk("wbusy_c2", wr_rdy, 1'b1);
    @(posedge aclk); #2;

    // reset in the middle of a line burst
    clear_seen();
    do_read(32'h1000, 3'b100);
    repeat (3) @(posedge aclk);
    #2;
    chk("mid_burst_valid", ret_valid, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("async_rst_valid", ret_valid, 1'b0);
    chk("async_rst_last", ret_last, 1'b0);
    chk("async_rst_data", ret_data, 32'h0);
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    clear_seen();
    @(negedge aclk);
    chk("post_rst_rd_rdy", rd_rdy, 1'b1);
    chk("post_rst_wr_rdy", wr_rdy, 1'b1);
    idle(10);
    chk("no_stale_beats", seen_data.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule

// File: doc/bridge_mem_responder.md
Name: bridge_mem_responder

Overview:
Behavioural memory responder for the cache-side bridge interface (rd_req/rd_rdy/ret_*, wr_req/wr_rdy). It is the slave end of the interface that icache/dcache drive toward the AXI bridge.
Lets cache units be exercised standalone, with no AXI fabric.
It holds a word-addressed array and has independent read and write channel FSMs.

Parameters:
MEM_WORDS, 16384, array depth in 32-bit words; power of two.
RD_LAT, 2, cycles from read accept to first ret_valid; must be >=1.
WR_LAT, 2, cycles wr_rdy stays low after a write accept; >=0.

Ports:
aclk       in   1    clock
aresetn    in   1    asynchronous active-low reset
rd_req     in   1    read request
rd_type    in   3    000 byte, 001 half, 010 word, 100 line(4 words); others treated as word
rd_addr    in   32   read byte address
rd_rdy     out  1    read channel can accept
ret_valid  out  1    return beat valid
ret_last   out  1    final beat of current read
ret_data   out  32   return beat data
wr_req     in   1    write request
wr_type    in   3    same encoding as rd_type
wr_addr    in   32   write byte address
wr_wstrb   in   4    byte enables for non-line writes
wr_data    in   128  write data; [31:0]=word0 ... [127:96]=word3
wr_rdy     out  1    write channel can accept

Behaviour:
- Reset (aresetn=0, async): both FSMs go to IDLE; ret_valid=0, ret_last=0, ret_data=0; rd_rdy=1 and wr_rdy=1 once released. Array contents are not cleared. Reset mid-burst aborts the burst; no further beats.
- Indexing: word index = addr[2 +: log2(MEM_WORDS)]. Upper bits ignored, so addresses alias. Line base = index with low 2 bits cleared.
- Read FSM: R_IDLE -> R_WAIT -> R_BEAT -> R_IDLE.
  - rd_rdy = (state==R_IDLE).
  - Accept on rd_req & rd_rdy at edge T. Snapshot the target word(s) into a 4x32 buffer at that edge. A write accepted on the same edge is forwarded into the snapshot, honouring byte strobes.
  - R_WAIT counts RD_LAT-1 cycles; it is skipped when RD_LAT=1.
  - First beat at T+RD_LAT. No backpressure; beats are on consecutive cycles.
  - Line read: 4 beats, word0..word3 in ascending order (no critical-word-first). ret_last on beat 4.
  - Non-line read: 1 beat, ret_last=1. Always the full aligned word; the requester extracts byte/half.
  - ret_data holds its last value when ret_valid=0.
  - Next accept is possible on the cycle after ret_last (rd_rdy rises that cycle).
- Write FSM: W_IDLE -> W_BUSY -> W_IDLE.
  - wr_rdy = (state==W_IDLE).
  - Accept on wr_req & wr_rdy commits to the array at that edge.
  - Line write: all 4 words, all bytes; wr_wstrb ignored.
  - Non-line write: wr_data[31:0] into the addressed word, per wr_wstrb. wr_wstrb=0 is a legal no-op.
  - W_BUSY lasts WR_LAT cycles. If WR_LAT=0, stay in W_IDLE, giving back-to-back accepts.
- The read and write channels are fully concurrent. Reads accepted after a write's accept edge see the write's data.
- Requests are ignored while the corresponding rdy is low. The requester holds req/addr/data until accepted.

Optional Feature:
MEMRSP_RAND_STALL_EN
- With the macro: an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle. rd_rdy and wr_rdy are additionally gated low when lfsr[0]=1 and lfsr[1]=1 respectively. Return timing after accept is unchanged.
- Without the macro: the LFSR is absent and rdy depends only on FSM state.

Decomposition:
- Shared package memrsp_pkg holds:
  - rd_type/wr_type constants: TYPE_BYTE=3'b000, TYPE_HALF=3'b001, TYPE_WORD=3'b010, TYPE_LINE=3'b100.
  - Read state encoding: R_IDLE, R_WAIT, R_BEAT.
  - Write state encoding: W_IDLE, W_BUSY.
  - LFSR seed and taps.
- One natural sub-module is memrsp_rd_ch: the read FSM, latency counter, beat counter and snapshot buffer. Write logic and the array stay in the top.

Test Plan:
- Line write then line read, RD_LAT=2:
  - Stimulus: wr_type=100, addr 0x1000, data {0x33333333,0x22222222,0x11111111,0x00000000}; then line read of 0x1008.
  - Required: first ret_valid exactly 2 cycles after accept; beats 0x00000000, 0x11111111, 0x22222222, 0x33333333; ret_last only on beat 4.
- Strobed write:
  - Stimulus: word 0x2000 preloaded 0xAABBCCDD; write wstrb=4'b0101, data 0x11223344; then word read.
  - Required: single beat 0xAA22CC44 with ret_last=1.
- Same-cycle forwarding:
  - Stimulus: word 0x3000 holds 0; wr_req and rd_req for 0x3000 on the same edge, write data 0xDEADBEEF, wstrb=4'hF.
  - Required: read returns 0xDEADBEEF.
- Aliasing:
  - Stimulus: MEM_WORDS=16384; write 0x12345678 to 0x0001_0004; read 0x0000_0004.
  - Required: read returns 0x12345678.
- Back-to-back reads and write busy window:
  - Stimulus: rd_req held high with two line reads queued.
  - Required: rd_rdy high on the cycle after ret_last; second burst starts RD_LAT cycles after its accept.
  - Stimulus: WR_LAT=2, one write accepted.
  - Required: wr_rdy low for exactly 2 cycles after accept.
- Reset mid-burst:
  - Stimulus: assert aresetn=0 after beat 2 of a line read.
  - Required: ret_valid drops immediately (async); after release rd_rdy=1, wr_rdy=1; no stale beats appear.
